// File: rtl/req_initiator.sv
// req_initiator
//
// Request/acknowledge initiator. On a start command it raises req toward a
// target and waits for the target's answer:
//   ack   - the target accepted; hold req for XFER_LEN transfer cycles, then
//           spend one END cycle flagging endtx and done.
//   retry - the target refused; drop req for BACKOFF cycles and reissue, up
//           to MAX_RETRY reissues, after which the attempt is abandoned.
//   busy  - the target is stalled; keep req up and pause the timeout.
//   none  - count toward TIMEOUT; abandon the attempt when it is reached.
// Abandoned attempts pulse fail for one cycle.
//
// Parameters
//   XFER_LEN  - transfer cycles after ack (1..255)
//   BACKOFF   - req-low cycles after a retry before reissue (1..255)
//   MAX_RETRY - reissues allowed before giving up
//   TIMEOUT   - non-busy cycles to wait for ack or retry (>= 1)
//
// Ports
//   clk       - system clock, rising edge
//   reset     - asynchronous, active-high reset
//   start     - begin one transaction (only looked at while idle)
//   ack       - target accepts the request
//   retry     - target rejects the request
//   busy      - target stalled
//   req       - request to target
//   endtx     - one-cycle end-of-transaction marker
//   done      - one-cycle successful completion pulse
//   fail      - one-cycle abort pulse (retry limit or timeout)
//   active    - high whenever a transaction is in progress
//   retry_cnt - retries taken in the current transaction
//
// All outputs come straight from flops. Their next values are derived from
// the next state so they line up with the state they describe.

module req_initiator #(
  parameter int XFER_LEN  = 4,
  parameter int BACKOFF   = 2,
  parameter int MAX_RETRY = 3,
  parameter int TIMEOUT   = 8,
  localparam int RCW      = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           ack,
  input  logic           retry,
  input  logic           busy,
  output logic           req,
  output logic           endtx,
  output logic           done,
  output logic           fail,
  output logic           active,
  output logic [RCW-1:0] retry_cnt
);

  localparam int XW = $clog2(XFER_LEN + 1);
  localparam int BW = $clog2(BACKOFF + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [XW-1:0]  XFER_LAST = XW'(XFER_LEN - 1);
  localparam logic [BW-1:0]  BO_LAST   = BW'(BACKOFF - 1);
  localparam logic [TW-1:0]  TMO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [RCW-1:0] RETRY_MAX = RCW'(MAX_RETRY);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_REQ     = 3'd1;
  localparam logic [2:0] S_XFER    = 3'd2;
  localparam logic [2:0] S_END     = 3'd3;
  localparam logic [2:0] S_BACKOFF = 3'd4;

  logic [2:0]     state_q, state_d;
  logic [RCW-1:0] retry_cnt_q, retry_cnt_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic [BW-1:0]  bo_q, bo_d;
  logic [XW-1:0]  xfer_q, xfer_d;
  logic           req_q, req_d;
  logic           endtx_q, endtx_d;
  logic           done_q, done_d;
  logic           fail_q, fail_d;
  logic           active_q, active_d;

  // Next-state and counter logic. In REQ the target's answer is resolved
  // with retry taking precedence over ack, and ack over busy.
  always_comb begin
    state_d     = state_q;
    retry_cnt_d = retry_cnt_q;
    tmo_d       = tmo_q;
    bo_d        = bo_q;
    xfer_d      = xfer_q;
    endtx_d     = 1'b0;
    done_d      = 1'b0;
    fail_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_REQ;
          retry_cnt_d = '0;
          tmo_d       = '0;
        end
      end

      S_REQ: begin
        if (retry) begin
          // retry_cnt keeps its final value after giving up so the
          // reason for the failure stays visible until the next start.
          if (retry_cnt_q == RETRY_MAX) begin
            state_d = S_IDLE;
            fail_d  = 1'b1;
          end else begin
            state_d     = S_BACKOFF;
            retry_cnt_d = retry_cnt_q + RCW'(1);
            tmo_d       = '0;
            bo_d        = '0;
          end
        end else if (ack) begin
          state_d = S_XFER;
          xfer_d  = '0;
        end else if (!busy) begin
          // busy freezes the timeout; only silent cycles count.
          tmo_d = tmo_q + TW'(1);
          if (tmo_q == TMO_LAST) begin
            state_d = S_IDLE;
            fail_d  = 1'b1;
          end
        end
      end

      S_BACKOFF: begin
        if (bo_q == BO_LAST) begin
          state_d = S_REQ;
        end else begin
          bo_d = bo_q + BW'(1);
        end
      end

      S_XFER: begin
        if (xfer_q == XFER_LAST) begin
          state_d = S_END;
          endtx_d = 1'b1;
          done_d  = 1'b1;
        end else begin
          xfer_d = xfer_q + XW'(1);
        end
      end

      S_END: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    req_d    = (state_d == S_REQ) || (state_d == S_XFER) || (state_d == S_END);
    active_d = (state_d != S_IDLE);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      retry_cnt_q <= '0;
      tmo_q       <= '0;
      bo_q        <= '0;
      xfer_q      <= '0;
      req_q       <= 1'b0;
      endtx_q     <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      active_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      retry_cnt_q <= retry_cnt_d;
      tmo_q       <= tmo_d;
      bo_q        <= bo_d;
      xfer_q      <= xfer_d;
      req_q       <= req_d;
      endtx_q     <= endtx_d;
      done_q      <= done_d;
      fail_q      <= fail_d;
      active_q    <= active_d;
    end
  end

  assign req       = req_q;
  assign endtx     = endtx_q;
  assign done      = done_q;
  assign fail      = fail_q;
  assign active    = active_q;
  assign retry_cnt = retry_cnt_q;

endmodule

// File: tb/tb_req_initiator.sv
// tb_req_initiator
//
// Drives directed scenarios into req_initiator (default parameters) and
// compares every cycle against a cycle-level reference model of the
// request protocol, plus hand-computed totals per scenario.

module tb_req_initiator;

  localparam int XFER_LEN  = 4;
  localparam int BACKOFF   = 2;
  localparam int MAX_RETRY = 3;
  localparam int TIMEOUT   = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, ack, retry, busy;
  logic       req, endtx, done, fail, active;
  logic [1:0] retry_cnt;

  int checks   = 0;
  int failures = 0;

  // Tallies gathered at every compared cycle
  int reqHigh, reqRise, lowActive, doneCnt, failCnt, endtxCnt, doneEnd;
  logic prevReq;

  req_initiator #(
    .XFER_LEN (XFER_LEN),
    .BACKOFF  (BACKOFF),
    .MAX_RETRY(MAX_RETRY),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .ack      (ack),
    .retry    (retry),
    .busy     (busy),
    .req      (req),
    .endtx    (endtx),
    .done     (done),
    .fail     (fail),
    .active   (active),
    .retry_cnt(retry_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: tracks which protocol phase the initiator is in and
  // how many cycles of that phase are left, counting down.
  localparam int PH_IDLE  = 10;
  localparam int PH_ASK   = 11;
  localparam int PH_DATA  = 12;
  localparam int PH_LAST  = 13;
  localparam int PH_PAUSE = 14;

  int   mPhase, mLeft, mSilent, mTries;
  logic eReq, eEndtx, eDone, eFail, eActive;
  int   eRc;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mPhase = PH_IDLE; mLeft = 0; mSilent = 0; mTries = 0;
      eReq = 0; eEndtx = 0; eDone = 0; eFail = 0; eActive = 0; eRc = 0;
    end else begin
      eDone = 0; eEndtx = 0; eFail = 0;
      case (mPhase)
        PH_IDLE: if (start) begin
          mPhase = PH_ASK; mTries = 0; mSilent = 0;
        end
        PH_ASK: begin
          if (retry) begin
            if (mTries == MAX_RETRY) begin
              mPhase = PH_IDLE; eFail = 1;
            end else begin
              mTries++; mSilent = 0; mLeft = BACKOFF; mPhase = PH_PAUSE;
            end
          end else if (ack) begin
            mLeft = XFER_LEN; mPhase = PH_DATA;
          end else if (!busy) begin
            mSilent++;
            if (mSilent == TIMEOUT) begin
              mPhase = PH_IDLE; eFail = 1;
            end
          end
        end
        PH_PAUSE: begin
          mLeft--;
          if (mLeft == 0) mPhase = PH_ASK;
        end
        PH_DATA: begin
          mLeft--;
          if (mLeft == 0) begin
            mPhase = PH_LAST; eDone = 1; eEndtx = 1;
          end
        end
        default: mPhase = PH_IDLE;
      endcase
      eReq    = (mPhase == PH_ASK) || (mPhase == PH_DATA) || (mPhase == PH_LAST);
      eActive = (mPhase != PH_IDLE);
      eRc     = mTries;
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Per-cycle comparison of all outputs against the model
  task automatic compareCycle();
    checks++;
    if ({req, endtx, done, fail, active} !== {eReq, eEndtx, eDone, eFail, eActive} ||
        int'(retry_cnt) !== eRc) begin
      failures++;
      $display("[TB] FAIL cycle@%0t: got req=%b endtx=%b done=%b fail=%b active=%b rc=%0d, expected req=%b endtx=%b done=%b fail=%b active=%b rc=%0d",
               $time, req, endtx, done, fail, active, retry_cnt,
               eReq, eEndtx, eDone, eFail, eActive, eRc);
    end
    if (req === 1'b1) reqHigh++;
    if (req === 1'b1 && prevReq !== 1'b1) reqRise++;
    if (active === 1'b1 && req === 1'b0) lowActive++;
    if (done === 1'b1) doneCnt++;
    if (fail === 1'b1) failCnt++;
    if (endtx === 1'b1) endtxCnt++;
    if (done === 1'b1 && endtx === 1'b1 && req === 1'b1) doneEnd++;
    prevReq = req;
  endtask

  task automatic clearTally();
    reqHigh = 0; reqRise = 0; lowActive = 0; doneCnt = 0;
    failCnt = 0; endtxCnt = 0; doneEnd = 0; prevReq = req;
  endtask

  // Inputs change just after a negedge; outputs are compared at the
  // following negedge, half a cycle clear of the active edge.
  task automatic applyStimulus(input logic s, input logic a, input logic r, input logic b);
    start = s; ack = a; retry = r; busy = b;
    @(posedge clk);
    @(negedge clk);
    compareCycle();
    #1;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0; ack = 1'b0; retry = 1'b0; busy = 1'b0;
    prevReq = 1'b0;
    #12;
    checkOutput("reset_outputs", int'({req, endtx, done, fail, active, retry_cnt}), 0);
    @(negedge clk);
    #1;
    reset = 1'b0;

    // Ack on the second request cycle
    clearTally();
    applyStimulus(1, 0, 0, 0);
    checkOutput("first_start_req", int'(req), 1);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0);
    idleCycles(6);
    checkOutput("s1_req_high", reqHigh, 7);
    checkOutput("s1_req_rise", reqRise, 1);
    checkOutput("s1_done", doneCnt, 1);
    checkOutput("s1_endtx", endtxCnt, 1);
    checkOutput("s1_done_endtx_req", doneEnd, 1);
    checkOutput("s1_req_after", int'(req), 0);

    // Two retries, then ack
    clearTally();
    applyStimulus(1, 0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      applyStimulus(0, 0, 1, 0);
      idleCycles(2);
    end
    applyStimulus(0, 1, 0, 0);
    idleCycles(5);
    checkOutput("s2_low_gap", lowActive, 4);
    checkOutput("s2_req_rise", reqRise, 3);
    checkOutput("s2_retry_cnt", int'(retry_cnt), 2);
    checkOutput("s2_done", doneCnt, 1);
    checkOutput("s2_fail", failCnt, 0);

    // Four retries: give up on the fourth
    clearTally();
    applyStimulus(1, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 0, 1, 0);
      idleCycles(2);
    end
    applyStimulus(0, 0, 1, 0);
    checkOutput("s3_fail_now", int'(fail), 1);
    checkOutput("s3_req_now", int'(req), 0);
    idleCycles(2);
    checkOutput("s3_fail", failCnt, 1);
    checkOutput("s3_endtx", endtxCnt, 0);
    checkOutput("s3_retry_cnt", int'(retry_cnt), 3);
    checkOutput("s3_low_gap", lowActive, 6);

    // Busy for 20 cycles, then ack
    clearTally();
    applyStimulus(1, 0, 0, 0);
    for (int k = 0; k < 20; k++) applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 1, 0, 0);
    idleCycles(5);
    checkOutput("s4_fail", failCnt, 0);
    checkOutput("s4_done", doneCnt, 1);
    checkOutput("s4_req_high", reqHigh, 26);

    // No response: timeout after 8 silent cycles
    clearTally();
    applyStimulus(1, 0, 0, 0);
    idleCycles(7);
    checkOutput("s5_no_fail_yet", failCnt, 0);
    idleCycles(1);
    checkOutput("s5_fail_now", int'(fail), 1);
    idleCycles(2);
    checkOutput("s5_req_high", reqHigh, 8);
    checkOutput("s5_fail", failCnt, 1);
    checkOutput("s5_done", doneCnt, 0);

    // Ack and retry together count as retry
    clearTally();
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 1, 1, 0);
    checkOutput("s6_req_low", int'(req), 0);
    checkOutput("s6_active", int'(active), 1);
    checkOutput("s6_retry_cnt", int'(retry_cnt), 1);
    idleCycles(2);
    applyStimulus(0, 1, 0, 0);
    idleCycles(5);
    checkOutput("s6_done", doneCnt, 1);

    // Reset in the second transfer cycle
    clearTally();
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("s7_async_req", int'(req), 0);
    checkOutput("s7_async_active", int'(active), 0);
    checkOutput("s7_async_pulses", int'({done, fail, endtx}), 0);
    @(negedge clk);
    #1;
    reset = 1'b0;
    checkOutput("s7_no_done", doneCnt, 0);
    checkOutput("s7_no_fail", failCnt, 0);
    clearTally();
    applyStimulus(1, 0, 0, 0);
    checkOutput("s7_restart_req", int'(req), 1);
    applyStimulus(0, 1, 0, 0);
    idleCycles(5);
    checkOutput("s7_done", doneCnt, 1);

    // Start held through transfer and END is ignored; one-cycle gap
    clearTally();
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 1, 0, 0);
    for (int k = 0; k < 4; k++) applyStimulus(1, 0, 0, 0);
    checkOutput("s8_in_end", int'(endtx), 1);
    applyStimulus(1, 0, 0, 0);
    checkOutput("s8_gap_req", int'(req), 0);
    checkOutput("s8_gap_active", int'(active), 0);
    applyStimulus(1, 0, 0, 0);
    checkOutput("s8_back_to_back", int'(req), 1);
    applyStimulus(0, 1, 0, 0);
    idleCycles(5);
    checkOutput("s8_done", doneCnt, 2);
    checkOutput("s8_req_rise", reqRise, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
